// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_if
// Purpose  : Bundle of the opcode/flag inputs and every datapath control
//            output of the multi-cycle sequencer.
// Modports : master - the sequencer (consumes op/zero, drives controls)
//            slave  - the datapath  (drives op/zero, consumes controls)
// Signals  : op[5:0], zero, PCWre, IRWre, InsMemRW, RegWre, RegDst[1:0],
//            WrRegData, ALUSrcB, ALUOp[2:0], ExtSel, mRD, mWR, DBDataSrc,
//            PCSrc[1:0], Halted, RetireCnt[31:0] (RETIRE_CNT_EN only)
// Macro    : RETIRE_CNT_EN adds the RetireCnt signal.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_cycle_ctrl_if;
  logic [5:0]  op;
  logic        zero;
  logic        PCWre;
  logic        IRWre;
  logic        InsMemRW;
  logic        RegWre;
  logic [1:0]  RegDst;
  logic        WrRegData;
  logic        ALUSrcB;
  logic [2:0]  ALUOp;
  logic        ExtSel;
  logic        mRD;
  logic        mWR;
  logic        DBDataSrc;
  logic [1:0]  PCSrc;
  logic        Halted;
`ifdef RETIRE_CNT_EN
  logic [31:0] RetireCnt;
`endif

  modport master (
    input  op,
    input  zero,
    output PCWre,
    output IRWre,
    output InsMemRW,
    output RegWre,
    output RegDst,
    output WrRegData,
    output ALUSrcB,
    output ALUOp,
    output ExtSel,
    output mRD,
    output mWR,
    output DBDataSrc,
    output PCSrc,
    output Halted
`ifdef RETIRE_CNT_EN
    , output RetireCnt
`endif
  );

  modport slave (
    output op,
    output zero,
    input  PCWre,
    input  IRWre,
    input  InsMemRW,
    input  RegWre,
    input  RegDst,
    input  WrRegData,
    input  ALUSrcB,
    input  ALUOp,
    input  ExtSel,
    input  mRD,
    input  mWR,
    input  DBDataSrc,
    input  PCSrc,
    input  Halted
`ifdef RETIRE_CNT_EN
    , input RetireCnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Purpose  : Multi-cycle control sequencer for the MIPS-subset datapath.
//            Steps each instruction through IF/ID/EXE/MEM/WB (or HALT),
//            latches the opcode at the end of IF and drives every datapath
//            enable and mux select from the current state and that opcode.
// Ports    : clk   - system clock, all state changes on posedge
//            rst_n - asynchronous active-low reset
//            bus   - multi_cycle_ctrl_if.master (op/zero in, controls out)
// Macro    : RETIRE_CNT_EN - adds a 32-bit retired-instruction counter
//            (bus.RetireCnt) that steps on every edge where PCWre is high.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl (
  input wire                 clk,
  input wire                 rst_n,
  multi_cycle_ctrl_if.master bus
);

  // --------------------------------------------------------------------------
  // Opcodes
  // --------------------------------------------------------------------------
  localparam logic [5:0] c_op_add  = 6'b000000;
  localparam logic [5:0] c_op_sub  = 6'b000001;
  localparam logic [5:0] c_op_addi = 6'b000010;
  localparam logic [5:0] c_op_or   = 6'b010000;
  localparam logic [5:0] c_op_and  = 6'b010001;
  localparam logic [5:0] c_op_ori  = 6'b010010;
  localparam logic [5:0] c_op_slt  = 6'b100110;
  localparam logic [5:0] c_op_sw   = 6'b110000;
  localparam logic [5:0] c_op_lw   = 6'b110001;
  localparam logic [5:0] c_op_beq  = 6'b110100;
  localparam logic [5:0] c_op_j    = 6'b111000;
  localparam logic [5:0] c_op_jr   = 6'b111001;
  localparam logic [5:0] c_op_jal  = 6'b111010;
  localparam logic [5:0] c_op_halt = 6'b111111;

  // ALU operation codes
  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_or  = 3'b010;
  localparam logic [2:0] c_alu_and = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b100;

  // PC source selects
  localparam logic [1:0] c_pc_seq  = 2'b00;
  localparam logic [1:0] c_pc_jmp  = 2'b10;
  localparam logic [1:0] c_pc_reg  = 2'b11;

  // Register destination selects
  localparam logic [1:0] c_dst_ra  = 2'b00;
  localparam logic [1:0] c_dst_rt  = 2'b01;
  localparam logic [1:0] c_dst_rd  = 2'b10;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // All registered control outputs in one bundle so they can be decoded
  // together for the state being entered.
  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       insmemrw;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrregdata;
    logic       alusrcb;
    logic [2:0] aluop;
    logic       extsel;
    logic       mrd;
    logic       mwr;
    logic       dbdatasrc;
    logic [1:0] pcsrc;
    logic       halted;
  } ctrl_t;

  // --------------------------------------------------------------------------
  // Opcode classification
  // --------------------------------------------------------------------------
  function automatic logic is_rtype(input logic [5:0] o);
    return (o == c_op_add) || (o == c_op_sub) || (o == c_op_or) ||
           (o == c_op_and) || (o == c_op_slt);
  endfunction

  // Arithmetic/logic instructions that write back an ALU result.
  function automatic logic is_alu(input logic [5:0] o);
    return is_rtype(o) || (o == c_op_addi) || (o == c_op_ori);
  endfunction

  function automatic logic is_known(input logic [5:0] o);
    return is_alu(o) || (o == c_op_sw) || (o == c_op_lw) ||
           (o == c_op_beq) || (o == c_op_j) || (o == c_op_jr) ||
           (o == c_op_jal) || (o == c_op_halt);
  endfunction

  function automatic logic [2:0] alu_op(input logic [5:0] o);
    logic [2:0] a;
    case (o)
      c_op_sub, c_op_beq: a = c_alu_sub;
      c_op_or,  c_op_ori: a = c_alu_or;
      c_op_and:           a = c_alu_and;
      c_op_slt:           a = c_alu_slt;
      default:            a = c_alu_add;   // add, addi, lw, sw
    endcase
    return a;
  endfunction

  // --------------------------------------------------------------------------
  // State transition rule
  // --------------------------------------------------------------------------
  function automatic state_t next_state(input state_t s, input logic [5:0] o);
    state_t n;
    case (s)
      S_IF: n = S_ID;
      S_ID: begin
        if (o == c_op_halt)
          n = S_HALT;
        else if ((o == c_op_j) || (o == c_op_jr) || (o == c_op_jal) || !is_known(o))
          n = S_IF;
        else
          n = S_EXE;
      end
      S_EXE: begin
        if (is_alu(o))
          n = S_WB;
        else if ((o == c_op_lw) || (o == c_op_sw))
          n = S_MEM;
        else
          n = S_IF;                      // beq
      end
      S_MEM:   n = (o == c_op_lw) ? S_WB : S_IF;
      S_WB:    n = S_IF;
      S_HALT:  n = S_HALT;
      default: n = S_IF;
    endcase
    return n;
  endfunction

  // --------------------------------------------------------------------------
  // Moore output decode for a given state/opcode pair
  // --------------------------------------------------------------------------
  function automatic ctrl_t decode(input state_t s, input logic [5:0] o);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.insmemrw = 1'b1;
        c.irwre    = 1'b1;
      end
      S_ID: begin
        if (o == c_op_j) begin
          c.pcwre = 1'b1;
          c.pcsrc = c_pc_jmp;
        end else if (o == c_op_jr) begin
          c.pcwre = 1'b1;
          c.pcsrc = c_pc_reg;
        end else if (o == c_op_jal) begin
          // Link write happens here: the PC still holds the jal address,
          // so PC+4 is the correct return address.
          c.pcwre     = 1'b1;
          c.pcsrc     = c_pc_jmp;
          c.regwre    = 1'b1;
          c.regdst    = c_dst_ra;
          c.wrregdata = 1'b0;
        end else if (!is_known(o)) begin
          c.pcwre = 1'b1;
          c.pcsrc = c_pc_seq;
        end
      end
      S_EXE: begin
        c.aluop   = alu_op(o);
        c.alusrcb = (o == c_op_addi) || (o == c_op_ori) ||
                    (o == c_op_lw)   || (o == c_op_sw);
        c.extsel  = (o != c_op_ori);
        // beq finishes here; its PCSrc is resolved from zero outside the
        // register because zero is only valid during this cycle.
        c.pcwre   = (o == c_op_beq);
      end
      S_MEM: begin
        c.mrd   = (o == c_op_lw);
        c.mwr   = (o == c_op_sw);
        c.pcwre = (o == c_op_sw);
      end
      S_WB: begin
        c.regwre    = 1'b1;
        c.wrregdata = 1'b1;
        c.pcwre     = 1'b1;
        c.regdst    = is_rtype(o) ? c_dst_rd : c_dst_rt;
        c.dbdatasrc = (o == c_op_lw);
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Registers and next-state logic
  // --------------------------------------------------------------------------
  state_t     r_state;
  logic [5:0] r_opcode;
  logic       r_run;        // low for the single idle cycle after reset release
  ctrl_t      r_ctrl;

  state_t     w_state_nxt;
  logic [5:0] w_opcode_nxt;
  ctrl_t      w_ctrl_nxt;
  logic       w_beq_exe;

  always_comb begin
    // IRWre is high only during a live IF cycle, so this captures op on
    // exactly the IF->ID edge.
    w_opcode_nxt = r_ctrl.irwre ? bus.op : r_opcode;
    // Out of reset the state already reads IF but no IF outputs have been
    // driven yet; hold IF for one edge so the first real IF cycle starts
    // after the first posedge.
    w_state_nxt  = r_run ? next_state(r_state, w_opcode_nxt) : S_IF;
    w_ctrl_nxt   = decode(w_state_nxt, w_opcode_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IF;
      r_opcode         <= 6'b000000;
      r_run            <= 1'b0;
      r_ctrl           <= '0;
      r_ctrl.regdst    <= c_dst_rd;
      r_ctrl.wrregdata <= 1'b1;
    end else begin
      r_run    <= 1'b1;
      r_state  <= w_state_nxt;
      r_opcode <= w_opcode_nxt;
      r_ctrl   <= w_ctrl_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign w_beq_exe = (r_state == S_EXE) && (r_opcode == c_op_beq);

  assign bus.PCWre     = r_ctrl.pcwre;
  assign bus.IRWre     = r_ctrl.irwre;
  assign bus.InsMemRW  = r_ctrl.insmemrw;
  assign bus.RegWre    = r_ctrl.regwre;
  assign bus.RegDst    = r_ctrl.regdst;
  assign bus.WrRegData = r_ctrl.wrregdata;
  assign bus.ALUSrcB   = r_ctrl.alusrcb;
  assign bus.ALUOp     = r_ctrl.aluop;
  assign bus.ExtSel    = r_ctrl.extsel;
  assign bus.mRD       = r_ctrl.mrd;
  assign bus.mWR       = r_ctrl.mwr;
  assign bus.DBDataSrc = r_ctrl.dbdatasrc;
  assign bus.Halted    = r_ctrl.halted;
  // Branch taken selects PC+4+(imm<<2); not taken falls through to PC+4.
  assign bus.PCSrc     = w_beq_exe ? {1'b0, bus.zero} : r_ctrl.pcsrc;

`ifdef RETIRE_CNT_EN
  // Counts instruction completions: PCWre fires once per instruction and
  // never in HALT. Wraps naturally at 32 bits.
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_retire_cnt <= 32'd0;
    else if (r_ctrl.pcwre)
      r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign bus.RetireCnt = r_retire_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Purpose  : Self-checking bench for multi_cycle_ctrl. A directed table of
//            instructions, a randomized instruction stream and hand-written
//            sequences (mid-instruction reset, halt) are compared cycle by
//            cycle against a phase-list reference model.
// Macro    : RETIRE_CNT_EN - also checks RetireCnt against the model count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;

  localparam logic [5:0] c_op_add  = 6'b000000;
  localparam logic [5:0] c_op_sub  = 6'b000001;
  localparam logic [5:0] c_op_addi = 6'b000010;
  localparam logic [5:0] c_op_or   = 6'b010000;
  localparam logic [5:0] c_op_and  = 6'b010001;
  localparam logic [5:0] c_op_ori  = 6'b010010;
  localparam logic [5:0] c_op_slt  = 6'b100110;
  localparam logic [5:0] c_op_sw   = 6'b110000;
  localparam logic [5:0] c_op_lw   = 6'b110001;
  localparam logic [5:0] c_op_beq  = 6'b110100;
  localparam logic [5:0] c_op_j    = 6'b111000;
  localparam logic [5:0] c_op_jr   = 6'b111001;
  localparam logic [5:0] c_op_jal  = 6'b111010;
  localparam logic [5:0] c_op_halt = 6'b111111;
  localparam logic [5:0] c_op_nop  = 6'b101010;

  localparam int c_ph_if   = 0;
  localparam int c_ph_id   = 1;
  localparam int c_ph_exe  = 2;
  localparam int c_ph_mem  = 3;
  localparam int c_ph_wb   = 4;
  localparam int c_ph_halt = 5;

  // Output vector layout:
  // {PCWre, IRWre, InsMemRW, RegWre, RegDst[1:0], WrRegData, ALUSrcB,
  //  ALUOp[2:0], ExtSel, mRD, mWR, DBDataSrc, PCSrc[1:0], Halted}
  localparam logic [17:0] c_reset_vec = {4'b0000, 2'b10, 1'b1, 1'b0, 3'b000,
                                         4'b0000, 2'b00, 1'b0};

  typedef int phase_q_t[$];

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         cycles;
    int         regwre;
    int         mwr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_retire;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "simulation time limit reached");
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic is_r(input logic [5:0] o);
    return o inside {c_op_add, c_op_sub, c_op_or, c_op_and, c_op_slt};
  endfunction

  function automatic logic is_arith(input logic [5:0] o);
    return is_r(o) || (o == c_op_addi) || (o == c_op_ori);
  endfunction

  function automatic logic known(input logic [5:0] o);
    return is_arith(o) || (o inside {c_op_sw, c_op_lw, c_op_beq, c_op_j,
                                     c_op_jr, c_op_jal, c_op_halt});
  endfunction

  // Sequence of phases an instruction visits before returning to IF.
  function automatic phase_q_t phases_of(input logic [5:0] o);
    phase_q_t q;
    q = {c_ph_if, c_ph_id};
    if (o == c_op_beq)      q.push_back(c_ph_exe);
    else if (o == c_op_sw)  begin q.push_back(c_ph_exe); q.push_back(c_ph_mem); end
    else if (o == c_op_lw)  begin q.push_back(c_ph_exe); q.push_back(c_ph_mem); q.push_back(c_ph_wb); end
    else if (is_arith(o))   begin q.push_back(c_ph_exe); q.push_back(c_ph_wb); end
    return q;
  endfunction

  function automatic logic [17:0] exp_vec(input int ph, input logic [5:0] o, input logic z);
    logic pcw, irw, imr, rw, wrd, asb, ext, mrd, mwr, dbs, hlt;
    logic [1:0] dst, pcs;
    logic [2:0] aop;
    {pcw, irw, imr, rw, wrd, asb, ext, mrd, mwr, dbs, hlt} = '0;
    dst = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (ph)
      c_ph_if: begin irw = 1'b1; imr = 1'b1; end
      c_ph_id: begin
        if (o == c_op_j)       begin pcw = 1'b1; pcs = 2'b10; end
        else if (o == c_op_jr) begin pcw = 1'b1; pcs = 2'b11; end
        else if (o == c_op_jal) begin pcw = 1'b1; pcs = 2'b10; rw = 1'b1; end
        else if (!known(o))    pcw = 1'b1;
      end
      c_ph_exe: begin
        if (o == c_op_sub || o == c_op_beq)     aop = 3'b001;
        else if (o == c_op_or || o == c_op_ori) aop = 3'b010;
        else if (o == c_op_and)                 aop = 3'b011;
        else if (o == c_op_slt)                 aop = 3'b100;
        asb = o inside {c_op_addi, c_op_ori, c_op_lw, c_op_sw};
        ext = (o != c_op_ori);
        if (o == c_op_beq) begin pcw = 1'b1; pcs = z ? 2'b01 : 2'b00; end
      end
      c_ph_mem: begin
        mrd = (o == c_op_lw);
        mwr = (o == c_op_sw);
        pcw = (o == c_op_sw);
      end
      c_ph_wb: begin
        rw = 1'b1; wrd = 1'b1; pcw = 1'b1;
        dst = is_r(o) ? 2'b10 : 2'b01;
        dbs = (o == c_op_lw);
      end
      c_ph_halt: hlt = 1'b1;
      default: ;
    endcase
    return {pcw, irw, imr, rw, dst, wrd, asb, aop, ext, mrd, mwr, dbs, pcs, hlt};
  endfunction

  function automatic logic [17:0] act_vec();
    return {bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.RegDst,
            bus.WrRegData, bus.ALUSrcB, bus.ALUOp, bus.ExtSel, bus.mRD,
            bus.mWR, bus.DBDataSrc, bus.PCSrc, bus.Halted};
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  task automatic check_retire(input string name);
`ifdef RETIRE_CNT_EN
    check(name, bus.RetireCnt, exp_retire);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // Runs one instruction. Entered at the negedge of its IF cycle; returns
  // at the negedge of the next IF cycle (or after a bounded cycle budget).
  task automatic run_instr(input logic [5:0] o, input logic z,
                           output int cyc, output int n_rw, output int n_mw, output int n_pw);
    phase_q_t ph;
    logic [17:0] a;
    ph = phases_of(o);
    cyc = 0; n_rw = 0; n_mw = 0; n_pw = 0;
    bus.op   = o;
    bus.zero = z;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (bus.IRWre) break;
      end
      if (k == 1) bus.op = 6'($urandom);   // opcode must already be latched
      a = act_vec();
      cyc++;
      n_rw += int'(bus.RegWre);
      n_mw += int'(bus.mWR);
      n_pw += int'(bus.PCWre);
      if (k < ph.size())
        check($sformatf("op %b z%0d cycle %0d", o, z, k), 32'(a), 32'(exp_vec(ph[k], o, z)));
    end
    exp_retire++;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  vec_t tbl[15];
  logic [5:0] pool[13];

  initial begin
    int cyc, n_rw, n_mw, n_pw;
    logic [5:0] o;
    logic z;
    phase_q_t ph;

    n_checks = 0; n_fail = 0; exp_retire = 0;

    tbl[0]  = '{c_op_add,  1'b0, 4, 1, 0};
    tbl[1]  = '{c_op_lw,   1'b1, 5, 1, 0};
    tbl[2]  = '{c_op_sw,   1'b0, 4, 0, 1};
    tbl[3]  = '{c_op_beq,  1'b1, 3, 0, 0};
    tbl[4]  = '{c_op_beq,  1'b0, 3, 0, 0};
    tbl[5]  = '{c_op_jal,  1'b0, 2, 1, 0};
    tbl[6]  = '{c_op_nop,  1'b1, 2, 0, 0};
    tbl[7]  = '{c_op_j,    1'b0, 2, 0, 0};
    tbl[8]  = '{c_op_jr,   1'b1, 2, 0, 0};
    tbl[9]  = '{c_op_sub,  1'b1, 4, 1, 0};
    tbl[10] = '{c_op_addi, 1'b0, 4, 1, 0};
    tbl[11] = '{c_op_or,   1'b0, 4, 1, 0};
    tbl[12] = '{c_op_and,  1'b1, 4, 1, 0};
    tbl[13] = '{c_op_ori,  1'b0, 4, 1, 0};
    tbl[14] = '{c_op_slt,  1'b1, 4, 1, 0};

    pool = '{c_op_add, c_op_sub, c_op_addi, c_op_or, c_op_and, c_op_ori,
             c_op_slt, c_op_sw, c_op_lw, c_op_beq, c_op_j, c_op_jr, c_op_jal};

    // Reset state
    rst_n = 1'b0; bus.op = 6'b000000; bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'(act_vec()), 32'(c_reset_vec));
    check_retire("reset RetireCnt");
    rst_n = 1'b1;
    #1;
    check("idle after release", 32'(act_vec()), 32'(c_reset_vec));
    @(negedge clk);   // first IF

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].op, tbl[i].zero, cyc, n_rw, n_mw, n_pw);
      check($sformatf("tbl%0d cycles", i), cyc, tbl[i].cycles);
      check($sformatf("tbl%0d RegWre pulses", i), n_rw, tbl[i].regwre);
      check($sformatf("tbl%0d mWR pulses", i), n_mw, tbl[i].mwr);
      check($sformatf("tbl%0d PCWre pulses", i), n_pw, 1);
      check_retire($sformatf("tbl%0d RetireCnt", i));
    end

    // Randomized stream including undefined opcodes
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        o = 6'($urandom);
        for (int t = 0; t < 64 && known(o); t++) o = 6'($urandom);
        if (known(o)) o = c_op_nop;
      end else begin
        o = pool[$urandom_range(0, 12)];
      end
      z = 1'($urandom);
      ph = phases_of(o);
      run_instr(o, z, cyc, n_rw, n_mw, n_pw);
      check($sformatf("rnd%0d op %b cycles", i, o), cyc, ph.size());
      check($sformatf("rnd%0d PCWre pulses", i), n_pw, 1);
    end
    check_retire("random RetireCnt");

    // Reset asserted during lw MEM aborts the instruction
    bus.op = c_op_lw;
    check("lw IF", 32'(act_vec()), 32'(exp_vec(c_ph_if, c_op_lw, 1'b0)));
    repeat (3) @(negedge clk);
    check("lw MEM before abort", 32'(act_vec()), 32'(exp_vec(c_ph_mem, c_op_lw, 1'b0)));
    #2 rst_n = 1'b0;
    #1;
    check("abort outputs immediate", 32'(act_vec()), 32'(c_reset_vec));
    exp_retire = 0;
    check_retire("abort RetireCnt");
    @(negedge clk);
    check("abort outputs held", 32'(act_vec()), 32'(c_reset_vec));
    rst_n = 1'b1;
    @(negedge clk);
    check("restart IF", 32'(act_vec()), 32'(exp_vec(c_ph_if, c_op_add, 1'b0)));
    run_instr(c_op_add, 1'b0, cyc, n_rw, n_mw, n_pw);
    check("restart add cycles", cyc, 4);
    check_retire("restart RetireCnt");

    // Halt is absorbing and not counted as retired
    bus.op = c_op_halt;
    check("halt IF", 32'(act_vec()), 32'(exp_vec(c_ph_if, c_op_halt, 1'b0)));
    @(negedge clk);
    check("halt ID", 32'(act_vec()), 32'(exp_vec(c_ph_id, c_op_halt, 1'b0)));
    bus.op = c_op_add;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.zero = 1'($urandom);
      check($sformatf("HALT cycle %0d", i), 32'(act_vec()), 32'(exp_vec(c_ph_halt, c_op_halt, 1'b0)));
    end
    check_retire("halt RetireCnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control sequencer for the single-issue MIPS-subset datapath. It steps each instruction through IF/ID/EXE/MEM/WB, latches the opcode, and drives every datapath enable and mux select, including the register file's RegWre, RegDst and WrRegData. It sits between the instruction register and the PC, ALU, data memory and register file. The register file writes on the negedge of clk inside the cycle in which RegWre is high.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode from instruction memory output, bits [31:26].
- zero  in  1  ALU result == 0.
- PCWre  out  1  PC load enable.
- IRWre  out  1  instruction register load enable.
- InsMemRW  out  1  instruction memory read.
- RegWre  out  1  register file write enable.
- RegDst  out  2  write destination: 00 = $31, 01 = rt, 10 = rd.
- WrRegData  out  1  write data select: 0 = PC+4, 1 = datapath write_data.
- ALUSrcB  out  1  0 = reg rt, 1 = extended immediate.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 slt.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- mRD, mWR  out  1 each  data memory read and write.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = jump target, 11 = rs (jr).
- Halted  out  1  high in the HALT state.

## Operation
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is a NOP.
- States: IF, ID, EXE, MEM, WB, HALT.
- Opcode register: captures op on the IF→ID edge, when IRWre is high. All decoding uses the latched value.

State transitions:
- IF → ID always.
- ID → IF for j, jr, jal and NOP.
- ID → HALT for halt.
- ID → EXE for all other opcodes.
- EXE → WB for arithmetic and logic opcodes.
- EXE → MEM for lw and sw.
- EXE → IF for beq.
- MEM → WB for lw; MEM → IF for sw.
- WB → IF.
- HALT is absorbing until reset.

Outputs are Moore-decoded from state and the latched opcode. Exception: PCSrc in beq EXE also uses zero (01 if zero, else 00). Any output not listed below is 0.
- IF: InsMemRW = 1, IRWre = 1.
- ID (j): PCWre = 1, PCSrc = 10.
- ID (jr): PCWre = 1, PCSrc = 11.
- ID (jal): PCWre = 1, PCSrc = 10, RegWre = 1, RegDst = 00, WrRegData = 0.
- ID (NOP): PCWre = 1, PCSrc = 00.
- EXE: ALUOp and ALUSrcB per opcode. ALUSrcB = 1 for addi, ori, lw and sw. ExtSel = 0 for ori only.
- EXE (beq): ALUOp = 001, PCWre = 1.
- MEM: mRD = 1 for lw. For sw, mWR = 1 and PCWre = 1.
- WB: RegWre = 1, WrRegData = 1, PCWre = 1.
  - RegDst = 10 for R-type, 01 for addi, ori and lw.
  - DBDataSrc = 1 for lw.
- HALT: all enables 0, Halted = 1.

## Timing
- Reset (asynchronous): state = IF, opcode register = 000000, retire counter = 0.
  - While rst_n is low, every enable (PCWre, IRWre, InsMemRW, RegWre, mRD, mWR) is forced to 0.
  - Reset values of the other outputs: RegDst = 10, WrRegData = 1, PCSrc = 00, ALUOp = 000, all remaining outputs 0.
- The first IF cycle follows the first posedge after rst_n deasserts.
- Cycle counts: j/jr/jal/NOP = 2; beq = 3; arithmetic and logic = 4; sw = 4; lw = 5.
- PCWre is high exactly once per instruction, in its final cycle, so the PC advances on the edge that returns to IF.
- The jal link uses PC+4 of the jal itself, because the PC has not yet updated during ID.
- A reset asserted mid-instruction aborts it; no partial register or memory write occurs after rst_n falls.
- zero is sampled only in beq EXE.

## Configuration
- RETIRE_CNT_EN defined: adds output RetireCnt (32 bits). It increments on every edge where PCWre = 1, wraps from 0xFFFFFFFF to 0, and is cleared by reset. It does not increment in HALT.
- RETIRE_CNT_EN undefined: no counter logic and no RetireCnt port.

## Test plan
- Reset release, then add (op 000000) → states IF, ID, EXE, WB. In WB: RegWre = 1, RegDst = 10, WrRegData = 1. Exactly one PCWre pulse.
- lw (110001) → 5 cycles. mRD = 1 in MEM. In WB: DBDataSrc = 1, RegDst = 01. sw (110000) → mWR = 1 and PCWre = 1 in MEM, RegWre never asserted.
- beq with zero = 1 → PCSrc = 01 in EXE. With zero = 0 → PCSrc = 00. Both take 3 cycles with RegWre = 0.
- jal (111010) → ID drives RegWre = 1, RegDst = 00, WrRegData = 0, PCSrc = 10, then IF. Undefined op 101010 → 2-cycle NOP with no writes.
- Assert rst_n low asynchronously during lw MEM → all enables drop to 0 immediately. After release, execution restarts in IF.
- halt (111111) → Halted = 1 and all enables 0 for more than 20 cycles. With RETIRE_CNT_EN, RetireCnt equals the number of completed instructions and does not count halt.
